// File: rtl/sisc_mc_if.sv
// sisc_mc_if -- instruction-fetch bus between the sisc_mc core and its
// instruction memory.
//
// Parameter:
//   PC_W     fetch address width (matches the core's program counter)
// Signals:
//   IM_REQ   core -> memory  fetch request, held until IM_ACK
//   IM_ADDR  core -> memory  fetch address (the program counter)
//   IM_ACK   memory -> core  IM_DATA is valid this cycle
//   IM_DATA  memory -> core  32-bit instruction word
// Modports:
//   master   the core side
//   slave    the memory side
interface sisc_mc_if #(
   parameter int PC_W = 16
) ();
   logic            IM_REQ;
   logic [PC_W-1:0] IM_ADDR;
   logic            IM_ACK;
   logic [31:0]     IM_DATA;

   modport master (
      output IM_REQ,
      output IM_ADDR,
      input  IM_ACK,
      input  IM_DATA
   );

   modport slave (
      input  IM_REQ,
      input  IM_ADDR,
      output IM_ACK,
      output IM_DATA
   );
endinterface

// File: rtl/sisc_mc.sv
// sisc_mc -- small multi-cycle integer core.
//
// Each instruction walks FETCH -> DECODE -> EXEC -> WB, so with a memory
// that acknowledges at once one instruction retires every 4 cycles. HALT
// parks the core in HLT until reset.
//
// Parameters:
//   DATA_W   datapath / register width (8..64)
//   NREG     register count, power of 2 (2..16); a register index is the
//            low clog2(NREG) bits of a 4-bit instruction field
//   PC_W     program counter width (4..16)
// Ports:
//   CLK      clock, rising edge
//   RST_F    asynchronous active-low reset
//   im       instruction-fetch bus (sisc_mc_if.master)
//   STAT     status flags {C,V,N,Z}
//   HALTED   core has executed HALT
//   WB_WE    register write strobe, one cycle
//   WB_REG   destination register field
//   WB_DATA  data written
//
// Instruction word: [31:28] opcode, [27:24] MM, [23:20] RS, [19:16] RT,
// [15:12] RD, [15:0] IMM.
//
// Build option: define SISC_MC_ZERO_REG_EN to make register 0 read as zero
// and ignore writes to it (WB_WE still pulses with WB_REG=0).
module sisc_mc #(
   parameter int DATA_W = 32,
   parameter int NREG   = 16,
   parameter int PC_W   = 16
) (
   input  logic              CLK,
   input  logic              RST_F,
   sisc_mc_if.master         im,
   output logic [3:0]        STAT,
   output logic              HALTED,
   output logic              WB_WE,
   output logic [3:0]        WB_REG,
   output logic [DATA_W-1:0] WB_DATA
);

   localparam int RIDX_W = $clog2(NREG);

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_WB,
      S_HLT
   } state_t;

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   state_t            state_q;
   logic [PC_W-1:0]   pc_q;
   logic [31:0]       ir_q;
   logic [3:0]        stat_q;
   logic              im_req_q;
   logic              halted_q;
   logic              wb_we_q;
   logic [3:0]        wb_reg_q;
   logic [DATA_W-1:0] wb_data_q;
   logic [DATA_W-1:0] a_q;          // first ALU operand, captured in DECODE
   logic [DATA_W-1:0] b_q;          // second ALU operand, captured in DECODE
   logic [DATA_W-1:0] regs_q [NREG];

   // ---------------------------------------------------------------------
   // Instruction fields
   // ---------------------------------------------------------------------
   logic [3:0]        op_f;
   logic [3:0]        mm_f;
   logic [3:0]        rs_f;
   logic [3:0]        rt_f;
   logic [3:0]        rd_f;
   logic [15:0]       imm_f;
   logic [3:0]        dst_f;
   logic [RIDX_W-1:0] rs_idx;
   logic [RIDX_W-1:0] rt_idx;
   logic [RIDX_W-1:0] dst_idx;
   logic              is_alu;
   logic [DATA_W-1:0] imm_sx;

   assign op_f    = ir_q[31:28];
   assign mm_f    = ir_q[27:24];
   assign rs_f    = ir_q[23:20];
   assign rt_f    = ir_q[19:16];
   assign rd_f    = ir_q[15:12];
   assign imm_f   = ir_q[15:0];

   assign is_alu  = (op_f == 4'h1) || (op_f == 4'h2);
   // Register-register ops write RD, register-immediate ops write RT.
   assign dst_f   = (op_f == 4'h1) ? rd_f : rt_f;

   assign rs_idx  = rs_f[RIDX_W-1:0];
   assign rt_idx  = rt_f[RIDX_W-1:0];
   assign dst_idx = dst_f[RIDX_W-1:0];

   // Sign-extend (or truncate, for DATA_W < 16) the immediate.
   assign imm_sx  = DATA_W'($signed(imm_f));

   // ---------------------------------------------------------------------
   // Register file read
   // ---------------------------------------------------------------------
   logic [DATA_W-1:0] rs_val;
   logic [DATA_W-1:0] rt_val;

   // NOTE: every variable driven by an always_comb gets an unconditional
   // assignment first, so no path can leave it holding a value (no latch).
   always_comb begin
      rs_val = regs_q[rs_idx];
      rt_val = regs_q[rt_idx];
`ifdef SISC_MC_ZERO_REG_EN
      if (rs_idx == '0) rs_val = '0;
      if (rt_idx == '0) rt_val = '0;
`endif
   end

   // ---------------------------------------------------------------------
   // ALU and flags
   // ---------------------------------------------------------------------
   logic [DATA_W:0]   ext_w;        // one extra bit catches carry / borrow
   logic [DATA_W-1:0] alu_res;
   logic              alu_c;
   logic              alu_v;
   logic [3:0]        stat_d;

   always_comb begin
      ext_w   = '0;
      alu_res = a_q;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (mm_f)
         4'h0: begin
            ext_w   = {1'b0, a_q} + {1'b0, b_q};
            alu_res = ext_w[DATA_W-1:0];
            alu_c   = ext_w[DATA_W];
            alu_v   = (a_q[DATA_W-1] == b_q[DATA_W-1]) &&
                      (alu_res[DATA_W-1] != a_q[DATA_W-1]);
         end
         4'h1: begin
            // C is the borrow: set when a_q < b_q as unsigned values.
            ext_w   = {1'b0, a_q} - {1'b0, b_q};
            alu_res = ext_w[DATA_W-1:0];
            alu_c   = ext_w[DATA_W];
            alu_v   = (a_q[DATA_W-1] != b_q[DATA_W-1]) &&
                      (alu_res[DATA_W-1] != a_q[DATA_W-1]);
         end
         4'h2:    alu_res = a_q & b_q;
         4'h3:    alu_res = a_q | b_q;
         4'h4:    alu_res = a_q ^ b_q;
         4'h5:    alu_res = ~a_q;
         4'h6:    alu_res = a_q << b_q[4:0];
         4'h7:    alu_res = a_q >> b_q[4:0];
         default: alu_res = a_q;
      endcase
   end

   assign stat_d = {alu_c, alu_v, alu_res[DATA_W-1], (alu_res == '0)};

   // ---------------------------------------------------------------------
   // Next PC
   // ---------------------------------------------------------------------
   logic            taken;
   logic [PC_W-1:0] pc_inc;
   logic [PC_W-1:0] pc_d;

   // MM==0 branches always; otherwise MM is a mask over {C,V,N,Z}.
   assign taken  = (mm_f == 4'h0) || ((stat_q & mm_f) != 4'h0);
   assign pc_inc = pc_q + PC_W'(1);

   // Adding the low PC_W bits of IMM equals adding the sign-extended
   // immediate modulo 2^PC_W.
   always_comb begin
      pc_d = pc_inc;
      if (taken) begin
         if (op_f == 4'h4)      pc_d = imm_f[PC_W-1:0];
         else if (op_f == 4'h5) pc_d = pc_inc + imm_f[PC_W-1:0];
      end
   end

   // ---------------------------------------------------------------------
   // Sequencer, register file and registered outputs
   // ---------------------------------------------------------------------
   // NOTE: all state here uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge CLK or negedge RST_F) begin
      if (!RST_F) begin
         state_q   <= S_FETCH;
         pc_q      <= '0;
         ir_q      <= '0;
         stat_q    <= '0;
         im_req_q  <= 1'b0;
         halted_q  <= 1'b0;
         wb_we_q   <= 1'b0;
         wb_reg_q  <= '0;
         wb_data_q <= '0;
         a_q       <= '0;
         b_q       <= '0;
         // NOTE: the register file must read as zero after reset, so it is
         // built from resettable flops rather than a RAM without reset.
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         wb_we_q <= 1'b0;
         case (state_q)
            S_FETCH: begin
               // The first cycle after reset only raises the request.
               if (!im_req_q) begin
                  im_req_q <= 1'b1;
               end else if (im.IM_ACK) begin
                  ir_q     <= im.IM_DATA;
                  im_req_q <= 1'b0;
                  state_q  <= S_DECODE;
               end
            end
            S_DECODE: begin
               a_q     <= rs_val;
               b_q     <= (op_f == 4'h2) ? imm_sx : rt_val;
               state_q <= S_EXEC;
            end
            S_EXEC: begin
               if (op_f == 4'hF) begin
                  halted_q <= 1'b1;
                  state_q  <= S_HLT;
               end else begin
                  // Results land on the edge entering WB, so WB_WE,
                  // STAT and the new PC are visible together.
                  pc_q    <= pc_d;
                  state_q <= S_WB;
                  if (is_alu) begin
                     stat_q    <= stat_d;
                     wb_we_q   <= 1'b1;
                     wb_reg_q  <= dst_f;
                     wb_data_q <= alu_res;
`ifdef SISC_MC_ZERO_REG_EN
                     if (dst_idx != '0) regs_q[dst_idx] <= alu_res;
`else
                     regs_q[dst_idx] <= alu_res;
`endif
                  end
               end
            end
            S_WB: begin
               // Request the next instruction straight away to keep the
               // 4-cycle rhythm.
               im_req_q <= 1'b1;
               state_q  <= S_FETCH;
            end
            S_HLT: begin
               im_req_q <= 1'b0;
            end
            default: begin
               state_q <= S_FETCH;
            end
         endcase
      end
   end

   assign im.IM_REQ  = im_req_q;
   assign im.IM_ADDR = pc_q;
   assign STAT       = stat_q;
   assign HALTED     = halted_q;
   assign WB_WE      = wb_we_q;
   assign WB_REG     = wb_reg_q;
   assign WB_DATA    = wb_data_q;

endmodule

// File: tb/tb_sisc_mc.sv
// tb_sisc_mc -- bench for sisc_mc.
//
// The bench plays instruction memory: it hands the core one instruction per
// fetch (directed words first, then random ones with random ACK delays) and
// runs each word through an instruction-level model of the core to predict
// WB_WE/WB_REG/WB_DATA, STAT and the next fetch address.
// Define SISC_MC_ZERO_REG_EN for both bench and RTL to exercise that build.
module tb_sisc_mc;
   localparam int DATA_W = 32;
   localparam int NREG   = 16;
   localparam int PC_W   = 16;

   localparam longint U_MAX = 64'h0000_0000_FFFF_FFFF;
   localparam longint S_MAX = 64'sh7FFF_FFFF;
   localparam longint S_MIN = -64'sh8000_0000;

   logic              CLK = 1'b0;
   logic              RST_F;
   logic [3:0]        STAT;
   logic              HALTED;
   logic              WB_WE;
   logic [3:0]        WB_REG;
   logic [DATA_W-1:0] WB_DATA;

   sisc_mc_if #(.PC_W(PC_W)) im_bus ();

   sisc_mc #(
      .DATA_W(DATA_W),
      .NREG  (NREG),
      .PC_W  (PC_W)
   ) dut (
      .CLK    (CLK),
      .RST_F  (RST_F),
      .im     (im_bus),
      .STAT   (STAT),
      .HALTED (HALTED),
      .WB_WE  (WB_WE),
      .WB_REG (WB_REG),
      .WB_DATA(WB_DATA)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------------------------------------------------------------
   // Instruction-level reference model
   // ---------------------------------------------------------------------
   logic [31:0] m_regs [16];
   logic [15:0] m_pc;
   logic [3:0]  m_stat;

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_regs[i] = 32'd0;
      m_pc   = 16'd0;
      m_stat = 4'd0;
   endtask

   function automatic logic [31:0] m_read(input logic [3:0] r);
`ifdef SISC_MC_ZERO_REG_EN
      if (r == 4'd0) return 32'd0;
`endif
      return m_regs[r];
   endfunction

   task automatic m_write(input logic [3:0] r, input logic [31:0] val);
`ifdef SISC_MC_ZERO_REG_EN
      if (r == 4'd0) return;
`endif
      m_regs[r] = val;
   endtask

   // Flags come from wide integer arithmetic: C is an unsigned overflow
   // (add) or borrow (sub), V a signed result outside the 32-bit range.
   task automatic m_alu(input logic [3:0] mm, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic c, output logic v);
      longint ua, ub, sa, sb, sr;
      ua = a;
      ub = b;
      sa = $signed(a);
      sb = $signed(b);
      res = a;
      c = 1'b0;
      v = 1'b0;
      case (mm)
         4'h0: begin
            res = a + b;
            c = (ua + ub) > U_MAX;
            sr = sa + sb;
            v = (sr > S_MAX) || (sr < S_MIN);
         end
         4'h1: begin
            res = a - b;
            c = ua < ub;
            sr = sa - sb;
            v = (sr > S_MAX) || (sr < S_MIN);
         end
         4'h2:    res = a & b;
         4'h3:    res = a | b;
         4'h4:    res = a ^ b;
         4'h5:    res = ~a;
         4'h6:    res = a << b[4:0];
         4'h7:    res = a >> b[4:0];
         default: res = a;
      endcase
   endtask

   task automatic model_exec(input logic [31:0] ins, output logic we, output logic [3:0] dreg,
                             output logic [31:0] data, output logic halt);
      logic [3:0]  op, mm, rs, rt, rd;
      logic [15:0] imm;
      logic [31:0] a, b, res;
      logic        c, v, taken;
      op  = ins[31:28];
      mm  = ins[27:24];
      rs  = ins[23:20];
      rt  = ins[19:16];
      rd  = ins[15:12];
      imm = ins[15:0];
      we = 1'b0;
      dreg = 4'd0;
      data = 32'd0;
      halt = 1'b0;
      taken = (mm == 4'h0) || ((m_stat & mm) != 4'h0);
      case (op)
         4'h1, 4'h2: begin
            a = m_read(rs);
            b = (op == 4'h1) ? m_read(rt) : {{16{imm[15]}}, imm};
            m_alu(mm, a, b, res, c, v);
            dreg = (op == 4'h1) ? rd : rt;
            m_write(dreg, res);
            m_stat = {c, v, res[31], res == 32'd0};
            we = 1'b1;
            data = res;
            m_pc = m_pc + 16'd1;
         end
         4'h4:    m_pc = taken ? imm : m_pc + 16'd1;
         4'h5:    m_pc = taken ? m_pc + 16'd1 + imm : m_pc + 16'd1;
         4'hF:    halt = 1'b1;
         default: m_pc = m_pc + 16'd1;
      endcase
   endtask

   // ---------------------------------------------------------------------
   // Drive one instruction through the core. Starts in the FETCH cycle,
   // returns at the negedge of the WB (or HLT) cycle.
   // ---------------------------------------------------------------------
   task automatic run_instr(input logic [31:0] ins, input int delay);
      logic        e_we, e_halt;
      logic [3:0]  e_reg;
      logic [31:0] e_data;
      @(negedge CLK);
      check("fetch_req", 64'(im_bus.IM_REQ), 64'd1);
      check("fetch_addr", 64'(im_bus.IM_ADDR), 64'(m_pc));
      check("fetch_we", 64'(WB_WE), 64'd0);
      for (int d = 0; d < delay; d++) begin
         im_bus.IM_ACK  = 1'b0;
         im_bus.IM_DATA = $urandom;
         @(negedge CLK);
         check("wait_req", 64'(im_bus.IM_REQ), 64'd1);
         check("wait_addr", 64'(im_bus.IM_ADDR), 64'(m_pc));
         check("wait_we", 64'(WB_WE), 64'd0);
      end
      im_bus.IM_ACK  = 1'b1;
      im_bus.IM_DATA = ins;
      @(negedge CLK);
      // Outside FETCH the ACK line carries noise that must be ignored.
      im_bus.IM_ACK  = 1'($urandom_range(1, 0));
      im_bus.IM_DATA = $urandom;
      check("dec_req", 64'(im_bus.IM_REQ), 64'd0);
      model_exec(ins, e_we, e_reg, e_data, e_halt);
      @(negedge CLK);
      check("exec_we", 64'(WB_WE), 64'd0);
      im_bus.IM_ACK  = 1'($urandom_range(1, 0));
      @(negedge CLK);
      if (e_halt) begin
         check("hlt_halted", 64'(HALTED), 64'd1);
         check("hlt_req", 64'(im_bus.IM_REQ), 64'd0);
         check("hlt_we", 64'(WB_WE), 64'd0);
      end else begin
         check("wb_we", 64'(WB_WE), 64'(e_we));
         if (e_we) begin
            check("wb_reg", 64'(WB_REG), 64'(e_reg));
            check("wb_data", 64'(WB_DATA), 64'(e_data));
         end
         check("wb_stat", 64'(STAT), 64'(m_stat));
         check("wb_pc", 64'(im_bus.IM_ADDR), 64'(m_pc));
         check("wb_req", 64'(im_bus.IM_REQ), 64'd0);
         check("wb_halted", 64'(HALTED), 64'd0);
      end
   endtask

   // Reset asserted while the core waits for IM_ACK in FETCH.
   task automatic reset_in_fetch();
      @(negedge CLK);
      im_bus.IM_ACK = 1'b0;
      check("abort_req_before", 64'(im_bus.IM_REQ), 64'd1);
      @(negedge CLK);
      #2 RST_F = 1'b0;
      #1;
      check("abort_req", 64'(im_bus.IM_REQ), 64'd0);
      check("abort_addr", 64'(im_bus.IM_ADDR), 64'd0);
      check("abort_stat", 64'(STAT), 64'd0);
      check("abort_we", 64'(WB_WE), 64'd0);
      model_reset();
      @(negedge CLK);
      RST_F = 1'b1;
   endtask

   function automatic logic [31:0] rand_instr();
      logic [3:0] op;
      int sel;
      sel = int'($urandom_range(9, 0));
      case (sel)
         0, 1, 2: op = 4'h1;
         3, 4, 5: op = 4'h2;
         6:       op = 4'h4;
         7:       op = 4'h5;
         8:       op = 4'h0;
         default: op = 4'($urandom_range(14, 6));
      endcase
      return {op, 28'($urandom)};
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      RST_F          = 1'b0;
      im_bus.IM_ACK  = 1'b0;
      im_bus.IM_DATA = 32'd0;
      model_reset();
      repeat (2) @(negedge CLK);

      check("rst_req", 64'(im_bus.IM_REQ), 64'd0);
      check("rst_addr", 64'(im_bus.IM_ADDR), 64'd0);
      check("rst_stat", 64'(STAT), 64'd0);
      check("rst_halted", 64'(HALTED), 64'd0);
      check("rst_we", 64'(WB_WE), 64'd0);
      check("rst_reg", 64'(WB_REG), 64'd0);
      check("rst_data", 64'(WB_DATA), 64'd0);

      RST_F = 1'b1;
      #1 check("rel_req_low", 64'(im_bus.IM_REQ), 64'd0);

      // R1 = R0 + 5
      run_instr(32'h2001_0005, 0);
      check("d1_reg", 64'(WB_REG), 64'd1);
      check("d1_data", 64'(WB_DATA), 64'd5);
      check("d1_stat", 64'(STAT), 64'd0);
      check("d1_next_addr", 64'(im_bus.IM_ADDR), 64'd1);

      // R2 = R1 - R1
      run_instr(32'h1111_2000, 0);
      check("d2_data", 64'(WB_DATA), 64'd0);
      check("d2_stat", 64'(STAT), 64'b0001);

      // Branch on Z (taken), then R1 = R1 + 1 clears Z, branch again (not taken)
      run_instr(32'h4100_0010, 0);
      check("d3_taken_addr", 64'(im_bus.IM_ADDR), 64'h0010);
      run_instr(32'h2011_0001, 0);
      run_instr(32'h4100_0010, 0);
      check("d4_not_taken_addr", 64'(im_bus.IM_ADDR), 64'h0012);

      // R1 = 0 - 1, R1 >>= 1, R1 = R1 + 1 (signed overflow)
      run_instr(32'h2101_0001, 0);
      run_instr(32'h2711_0001, 0);
      check("d5_max_pos", 64'(WB_DATA), 64'h7FFF_FFFF);
      run_instr(32'h2011_0001, 0);
      check("d6_ovf_data", 64'(WB_DATA), 64'h8000_0000);
      check("d6_ovf_stat", 64'(STAT), 64'b0110);

      // Late acknowledge
      run_instr(32'h2003_0009, 3);

      for (int i = 0; i < 80; i++) begin
         int dly;
         dly = ($urandom_range(3, 0) == 0) ? int'($urandom_range(3, 1)) : 0;
         run_instr(rand_instr(), dly);
      end

      // Move PC away from zero, then reset during a fetch wait
      run_instr(32'h4000_1234, 0);
      check("d7_far_addr", 64'(im_bus.IM_ADDR), 64'h1234);
      reset_in_fetch();

      // Register 0 behaviour
      run_instr(32'h2000_0007, 0);
      check("z1_reg", 64'(WB_REG), 64'd0);
      check("z1_data", 64'(WB_DATA), 64'd7);
      run_instr(32'h2002_0000, 0);
      check("z2_reg", 64'(WB_REG), 64'd2);
`ifdef SISC_MC_ZERO_REG_EN
      check("z2_data", 64'(WB_DATA), 64'd0);
`else
      check("z2_data", 64'(WB_DATA), 64'd7);
`endif

      for (int i = 0; i < 20; i++) begin
         run_instr(rand_instr(), int'($urandom_range(1, 0)));
      end

      // HALT, then the core must stay parked whatever the bus does
      run_instr(32'hF000_0000, 0);
      for (int i = 0; i < 12; i++) begin
         im_bus.IM_ACK  = 1'b1;
         im_bus.IM_DATA = $urandom;
         @(negedge CLK);
         check("halt_req", 64'(im_bus.IM_REQ), 64'd0);
         check("halt_flag", 64'(HALTED), 64'd1);
         check("halt_we", 64'(WB_WE), 64'd0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/sisc_mc.md
SISC_MC -- requirements
Module: sisc_mc

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning datapath and register width (8..64).
REQ-002 SHALL have parameter NREG, default 16, meaning register count (power of 2, 2..16); register index is the low clog2(NREG) bits of each 4-bit field.
REQ-003 SHALL have parameter PC_W, default 16, meaning program counter width (4..16).
REQ-004 SHALL have port CLK  in  1  meaning the single clock; all state updates on the rising edge.
REQ-005 SHALL have port RST_F  in  1  meaning reset, asynchronous and active-low.
REQ-006 SHALL have port IM_REQ  out  1  meaning instruction fetch request.
REQ-007 SHALL have port IM_ADDR  out  PC_W  meaning fetch address, equal to PC.
REQ-008 SHALL have port IM_ACK  in  1  meaning fetch data valid this cycle.
REQ-009 SHALL have port IM_DATA  in  32  meaning instruction word.
REQ-010 SHALL have port STAT  out  4  meaning status flags {C,V,N,Z}.
REQ-011 SHALL have port HALTED  out  1  meaning the core has executed HALT.
REQ-012 SHALL have port WB_WE  out  1  meaning register write strobe, one cycle.
REQ-013 SHALL have port WB_REG  out  4  meaning destination register index.
REQ-014 SHALL have port WB_DATA  out  DATA_W  meaning data written.

Function
REQ-015 SHALL decode IR as [31:28] opcode, [27:24] MM, [23:20] RS, [19:16] RT, [15:12] RD, [15:0] IMM.
REQ-016 SHALL implement opcodes: 0 NOP; 1 RD<=RS op RT; 2 RT<=RS op sext(IMM); 4 BRA PC<=IMM[PC_W-1:0]; 5 BRR PC<=PC+1+sext(IMM); F HALT; all others execute as NOP.
REQ-017 SHALL select the ALU op by MM: 0 add, 1 sub (RS-RT), 2 and, 3 or, 4 xor, 5 not RS, 6 shl RS by RT[4:0], 7 shr logical; MM 8..F writes RS unchanged.
REQ-018 SHALL take a branch when MM==0 or (STAT & MM)!=0; otherwise PC<=PC+1.
REQ-019 SHALL update STAT only on opcodes 1 and 2: Z=result==0, N=result msb, C/V from add/sub at DATA_W bits, C=V=0 for other ops.
REQ-020 SHALL sequence FETCH -> DECODE -> EXEC -> WB -> FETCH; HALT enters state HLT permanently until reset.
REQ-021 SHALL in FETCH hold IM_REQ=1 with IM_ADDR stable until IM_ACK=1, latch IM_DATA into IR on that edge, and leave FETCH.
REQ-022 SHALL ignore IM_ACK outside FETCH.
REQ-023 SHALL in WB pulse WB_WE for exactly one cycle with WB_REG/WB_DATA for opcodes 1 and 2, and update PC and STAT on the same edge.
REQ-024 SHALL give, with IM_ACK tied high, one instruction per 4 cycles; WB_WE asserts in the 4th cycle after IM_REQ rises.
REQ-025 SHALL wrap PC modulo 2^PC_W on increment and relative branch.
REQ-026 SHALL read operands in DECODE, so an instruction sees the previous instruction's writeback.
REQ-027 SHALL in HLT drive IM_REQ=0, WB_WE=0, HALTED=1.

Reset
REQ-028 SHALL on RST_F low immediately force state FETCH, PC=0, IR=0, STAT=0000, all registers 0, IM_REQ=0, HALTED=0, WB_WE=0, WB_REG=0, WB_DATA=0, aborting any instruction in progress.
REQ-029 SHALL assert IM_REQ on the first rising CLK edge after RST_F deasserts.

Configuration
REQ-030 SHALL, with SISC_MC_ZERO_REG_EN defined, read register 0 as zero and suppress writes to it; WB_WE still pulses with WB_REG=0.
REQ-031 SHALL, without SISC_MC_ZERO_REG_EN, treat register 0 as an ordinary register.

Verification
REQ-032 SHALL cover: IM_ACK=1, IM_DATA=0x20010005 -> WB_WE with WB_REG=1, WB_DATA=5, STAT=0000, next IM_ADDR=1.
REQ-033 SHALL cover: R1=5, then 0x11112000 (R2=R1-R1) -> WB_DATA=0, STAT=0001; then 0x41000010 -> next IM_ADDR=0x0010; the same branch with Z=0 -> IM_ADDR=PC+1.
REQ-034 SHALL cover: R1=0x7FFFFFFF, then 0x20110001 -> WB_DATA=0x80000000, STAT=0110.
REQ-035 SHALL cover: IM_ACK delayed 3 cycles -> IM_REQ held, IM_ADDR stable, no WB_WE until 3 cycles after the ACK.
REQ-036 SHALL cover: 0xF0000000 -> HALTED=1, IM_REQ=0 indefinitely; RST_F low during a FETCH wait -> IM_REQ=0 immediately, IM_ADDR=0.
REQ-037 SHALL cover: with SISC_MC_ZERO_REG_EN, 0x20000007 then 0x20020000 -> R2 written 0.
